// File: rtl/prbs_seq_mc.sv
// Multi-lane PRBS link self-test sequencer: brings up generators/checkers, proves error
// detection with a timed injection window, waits for clean lanes, then tracks per-lane errors.
module prbs_seq_mc #(
    parameter int unsigned          NCH            = 4,
    parameter int unsigned          MODE_W         = 3,
    parameter logic [MODE_W-1:0]    PRBS_MODE      = 3'b100,
    parameter int unsigned          INJECT_CYCLES  = 1_000_000_000,
    parameter int unsigned          SETTLE_CYCLES  = 512,
    parameter int unsigned          TIMEOUT_CYCLES = 1_048_576,
    parameter int unsigned          ERRCNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pll_lock,
    input  logic                    alldone,
    input  logic                    rerun,
    input  logic [NCH-1:0]          rx_prbs_err,
    input  logic [NCH-1:0]          checker_status,
    input  logic                    prbscntreset_ext,
    input  logic                    error_inject_ext,
    output logic [NCH*MODE_W-1:0]   tx_prbs_mode,
    output logic [NCH*MODE_W-1:0]   rx_prbs_mode,
    output logic                    prbscntreset,
    output logic                    error_inject,
    output logic [NCH-1:0]          inject_seen,
    output logic [NCH*ERRCNT_W-1:0] lane_err_cnt,
    output logic                    test_pass,
    output logic                    test_fail,
    output logic [3:0]              state
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_DONE = 4'd1,
        ST_TX_ON     = 4'd2,
        ST_RX_ON     = 4'd3,
        ST_INJECT    = 4'd4,
        ST_DRAIN     = 4'd5,
        ST_CLEAR     = 4'd6,
        ST_ACTIVE    = 4'd7,
        ST_FAIL      = 4'd8
    } state_t;

    localparam int unsigned INJ_W = $clog2(INJECT_CYCLES + 1);
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INJ_W-1:0] INJ_LAST = INJ_W'(INJECT_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           cur, nxt;
    logic [INJ_W-1:0] inj_cnt;
    logic [SET_W-1:0] settle_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             clean, settle_done, timed_out, in_window, counting;

    assign state = cur;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        nxt         = cur;
        clean       = ~|rx_prbs_err && ~|checker_status;
        settle_done = (cur == ST_CLEAR) && clean && (settle_cnt == SET_LAST);
        timed_out   = (to_cnt == TO_LAST);
        if (!pll_lock) begin
            nxt = ST_IDLE;
        end else if (rerun && (cur == ST_ACTIVE || cur == ST_FAIL)) begin
            nxt = ST_TX_ON;
        end else begin
            unique case (cur)
                ST_IDLE:      nxt = ST_WAIT_DONE;
                ST_WAIT_DONE: nxt = alldone ? ST_TX_ON : ST_WAIT_DONE;
                ST_TX_ON:     nxt = ST_RX_ON;
                ST_RX_ON:     nxt = ST_INJECT;
                ST_INJECT:    nxt = (inj_cnt == INJ_LAST) ? ST_DRAIN : ST_INJECT;
                ST_DRAIN: begin
                    if (timed_out)          nxt = ST_FAIL;
                    else if (~|rx_prbs_err) nxt = ST_CLEAR;
                end
                // A settle completing on the timeout cycle still counts as settled.
                ST_CLEAR: begin
                    if (settle_done)    nxt = (&inject_seen) ? ST_ACTIVE : ST_FAIL;
                    else if (timed_out) nxt = ST_FAIL;
                end
                ST_ACTIVE:    nxt = ST_ACTIVE;
                ST_FAIL:      nxt = ST_FAIL;
                default:      nxt = ST_IDLE;
            endcase
        end
        in_window = (cur == ST_DRAIN || cur == ST_CLEAR) && (nxt == ST_DRAIN || nxt == ST_CLEAR);
        counting  = (cur == ST_ACTIVE) && (nxt == ST_ACTIVE);
    end

    // Outputs are computed from the next state so each one lines up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur          <= ST_IDLE;
            inj_cnt      <= '0;
            settle_cnt   <= '0;
            to_cnt       <= '0;
            tx_prbs_mode <= '0;
            rx_prbs_mode <= '0;
            prbscntreset <= 1'b0;
            error_inject <= 1'b0;
            inject_seen  <= '0;
            lane_err_cnt <= '0;
            test_pass    <= 1'b0;
            test_fail    <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            cur        <= nxt;
            inj_cnt    <= (cur == ST_INJECT && nxt == ST_INJECT) ? inj_cnt + 1'b1 : '0;
            to_cnt     <= in_window ? to_cnt + 1'b1 : '0;
            settle_cnt <= (cur == ST_CLEAR && nxt == ST_CLEAR && clean) ? settle_cnt + 1'b1 : '0;

            tx_prbs_mode <= (nxt == ST_IDLE || nxt == ST_WAIT_DONE) ? '0 : {NCH{PRBS_MODE}};
            rx_prbs_mode <= (nxt == ST_IDLE || nxt == ST_WAIT_DONE || nxt == ST_TX_ON)
                            ? '0 : {NCH{PRBS_MODE}};
            prbscntreset <= (nxt == ST_CLEAR)  || (nxt == ST_ACTIVE && prbscntreset_ext);
            error_inject <= (nxt == ST_INJECT) || (nxt == ST_ACTIVE && error_inject_ext);
            test_pass    <= (nxt == ST_ACTIVE);
            test_fail    <= (nxt == ST_FAIL);

            if (nxt == ST_IDLE || nxt == ST_RX_ON)
                inject_seen <= '0;
            else if (cur == ST_INJECT)
                inject_seen <= inject_seen | rx_prbs_err;

            // Leaving ACTIVE (rerun or lock loss) clears the counts; the external clear beats an error.
            for (int i = 0; i < NCH; i++) begin
                if (!counting || prbscntreset_ext)
                    lane_err_cnt[i*ERRCNT_W +: ERRCNT_W] <= '0;
                else if (rx_prbs_err[i] && lane_err_cnt[i*ERRCNT_W +: ERRCNT_W] != '1)
                    lane_err_cnt[i*ERRCNT_W +: ERRCNT_W] <= lane_err_cnt[i*ERRCNT_W +: ERRCNT_W] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prbs_seq_mc.sv
// Bench for prbs_seq_mc: directed vector table, ACTIVE-phase corner sequences and a
// randomized run, all compared every cycle against a behavioural model of the sequencer.
module tb_prbs_seq_mc;

    localparam int NCH = 4, MODE_W = 3, INJ = 20, SETTLE = 8, TMO = 64, EW = 16;
    localparam int S_IDLE = 0, S_WAIT = 1, S_TX = 2, S_RX = 3, S_INJ = 4,
                   S_DRAIN = 5, S_CLEAR = 6, S_ACTIVE = 7, S_FAIL = 8;

    logic                  clk = 1'b0;
    logic                  reset, pll_lock, alldone, rerun;
    logic [NCH-1:0]        rx_prbs_err, checker_status;
    logic                  prbscntreset_ext, error_inject_ext;
    logic [NCH*MODE_W-1:0] tx_prbs_mode, rx_prbs_mode;
    logic                  prbscntreset, error_inject;
    logic [NCH-1:0]        inject_seen;
    logic [NCH*EW-1:0]     lane_err_cnt;
    logic                  test_pass, test_fail;
    logic [3:0]            state;

    int total = 0;
    int bad   = 0;

    prbs_seq_mc #(
        .NCH(NCH), .MODE_W(MODE_W), .PRBS_MODE(3'b100), .INJECT_CYCLES(INJ),
        .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO), .ERRCNT_W(EW)
    ) dut (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .alldone(alldone), .rerun(rerun),
        .rx_prbs_err(rx_prbs_err), .checker_status(checker_status),
        .prbscntreset_ext(prbscntreset_ext), .error_inject_ext(error_inject_ext),
        .tx_prbs_mode(tx_prbs_mode), .rx_prbs_mode(rx_prbs_mode),
        .prbscntreset(prbscntreset), .error_inject(error_inject), .inject_seen(inject_seen),
        .lane_err_cnt(lane_err_cnt), .test_pass(test_pass), .test_fail(test_fail), .state(state)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase plus elapsed-cycle bookkeeping per the sequencer's rules.
    int       m_state, m_inj, m_win, m_run;
    int       m_cnt[NCH];
    bit [3:0] m_seen;
    bit       m_pcr, m_ei;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_inj = 0; m_win = 0; m_run = 0;
        m_seen = '0; m_pcr = 0; m_ei = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
    endtask

    task automatic model_update();
        int s, ns;
        bit all_clean;
        s = m_state;
        ns = s;
        all_clean = (rx_prbs_err == 0) && (checker_status == 0);
        if (!pll_lock) begin
            ns = S_IDLE;
            m_seen = '0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else if (rerun && (s == S_ACTIVE || s == S_FAIL)) begin
            ns = S_TX;
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else begin
            case (s)
                S_IDLE: ns = S_WAIT;
                S_WAIT: ns = alldone ? S_TX : S_WAIT;
                S_TX:   ns = S_RX;
                S_RX: begin ns = S_INJ; m_inj = 0; end
                S_INJ: begin
                    m_seen |= rx_prbs_err;
                    m_inj++;
                    if (m_inj == INJ) begin ns = S_DRAIN; m_win = 0; end
                end
                S_DRAIN: begin
                    m_win++;
                    if (m_win >= TMO) ns = S_FAIL;
                    else if (rx_prbs_err == 0) begin ns = S_CLEAR; m_run = 0; end
                end
                S_CLEAR: begin
                    m_win++;
                    m_run = all_clean ? m_run + 1 : 0;
                    if (m_run >= SETTLE) ns = (m_seen == 4'hF) ? S_ACTIVE : S_FAIL;
                    else if (m_win >= TMO) ns = S_FAIL;
                end
                S_ACTIVE: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (prbscntreset_ext)    m_cnt[i] = 0;
                        else if (rx_prbs_err[i]) m_cnt[i] = (m_cnt[i] + 1 > 65535) ? 65535 : m_cnt[i] + 1;
                    end
                end
                S_FAIL: ns = S_FAIL;
                default: ns = S_IDLE;
            endcase
        end
        if (ns == S_RX) m_seen = '0;
        m_pcr   = (ns == S_CLEAR) || (ns == S_ACTIVE && prbscntreset_ext);
        m_ei    = (ns == S_INJ)   || (ns == S_ACTIVE && error_inject_ext);
        m_state = ns;
    endtask

    task automatic compare_all(input string name);
        logic [99:0]     act, exp;
        logic [11:0]     etx, erx;
        logic [NCH*EW-1:0] ecnt;
        etx = (m_state >= S_TX) ? {NCH{3'b100}} : '0;
        erx = (m_state >= S_RX) ? {NCH{3'b100}} : '0;
        for (int i = 0; i < NCH; i++) ecnt[i*EW +: EW] = EW'(m_cnt[i]);
        act = {state, tx_prbs_mode, rx_prbs_mode, prbscntreset, error_inject, inject_seen,
               lane_err_cnt, test_pass, test_fail};
        exp = {4'(m_state), etx, erx, m_pcr, m_ei, m_seen, ecnt,
               m_state == S_ACTIVE, m_state == S_FAIL};
        check(name, {28'h0, act}, {28'h0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all("cycle");
    endtask

    typedef struct {
        int       n;
        bit       lock, done, rr;
        bit [3:0] err, chk;
        bit [3:0] st;
        bit       pass, fail;
        bit [3:0] seen;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input bit lock, input bit done, input bit [3:0] err,
                       input bit [3:0] chk, input bit rr, input bit [3:0] st,
                       input bit pass, input bit fail, input bit [3:0] seen);
        vec_t v;
        v.n = n; v.lock = lock; v.done = done; v.err = err; v.chk = chk; v.rr = rr;
        v.st = st; v.pass = pass; v.fail = fail; v.seen = seen;
        tbl.push_back(v);
    endtask

    bit [3:0] dead_mask;

    initial begin
        reset = 1'b0; pll_lock = 1'b1; alldone = 1'b0; rerun = 1'b0;
        rx_prbs_err = '0; checker_status = '0; prbscntreset_ext = 1'b0; error_inject_ext = 1'b0;

        //  n  lock done err   chk  rr  state pass fail seen
        // nominal: alldone at cycle 5, all lanes error during INJECT
        add(1,  1, 0, 4'h0, 4'h0, 0, 4'd1, 0, 0, 4'h0);
        add(4,  1, 0, 4'h0, 4'h0, 0, 4'd1, 0, 0, 4'h0);
        add(1,  1, 1, 4'h0, 4'h0, 0, 4'd2, 0, 0, 4'h0);
        add(1,  1, 1, 4'h0, 4'h0, 0, 4'd3, 0, 0, 4'h0);
        add(1,  1, 0, 4'hF, 4'h0, 0, 4'd4, 0, 0, 4'h0);
        add(19, 1, 0, 4'hF, 4'h0, 0, 4'd4, 0, 0, 4'hF);
        add(1,  1, 0, 4'h0, 4'h0, 0, 4'd5, 0, 0, 4'hF);
        add(1,  1, 0, 4'h0, 4'h0, 0, 4'd6, 0, 0, 4'hF);
        add(7,  1, 0, 4'h0, 4'h0, 0, 4'd6, 0, 0, 4'hF);
        add(1,  1, 0, 4'h0, 4'h0, 0, 4'd7, 1, 0, 4'hF);
        // rerun from ACTIVE; lane 2 silent during INJECT -> FAIL
        add(1,  1, 0, 4'h0, 4'h0, 1, 4'd2, 0, 0, 4'hF);
        add(1,  1, 0, 4'h0, 4'h0, 0, 4'd3, 0, 0, 4'h0);
        add(1,  1, 0, 4'hB, 4'h0, 0, 4'd4, 0, 0, 4'h0);
        add(19, 1, 0, 4'hB, 4'h0, 0, 4'd4, 0, 0, 4'hB);
        add(1,  1, 0, 4'h0, 4'h0, 0, 4'd5, 0, 0, 4'hB);
        add(1,  1, 0, 4'h0, 4'h0, 0, 4'd6, 0, 0, 4'hB);
        add(7,  1, 0, 4'h0, 4'h0, 0, 4'd6, 0, 0, 4'hB);
        add(1,  1, 0, 4'h0, 4'h0, 0, 4'd8, 0, 1, 4'hB);
        // rerun from FAIL; lane 0 checker stuck bad -> FAIL 64 cycles after DRAIN entry
        add(1,  1, 0, 4'h0, 4'h0, 1, 4'd2, 0, 0, 4'hB);
        add(1,  1, 0, 4'h0, 4'h0, 0, 4'd3, 0, 0, 4'h0);
        add(1,  1, 0, 4'hF, 4'h0, 0, 4'd4, 0, 0, 4'h0);
        add(19, 1, 0, 4'hF, 4'h0, 0, 4'd4, 0, 0, 4'hF);
        add(1,  1, 0, 4'h0, 4'h1, 0, 4'd5, 0, 0, 4'hF);
        add(1,  1, 0, 4'h0, 4'h1, 0, 4'd6, 0, 0, 4'hF);
        add(62, 1, 0, 4'h0, 4'h1, 0, 4'd6, 0, 0, 4'hF);
        add(1,  1, 0, 4'h0, 4'h1, 0, 4'd8, 0, 1, 4'hF);
        // pll_lock dropped mid-INJECT, relock reruns; rerun during INJECT ignored
        add(1,  1, 0, 4'h0, 4'h0, 1, 4'd2, 0, 0, 4'hF);
        add(1,  1, 0, 4'h0, 4'h0, 0, 4'd3, 0, 0, 4'h0);
        add(1,  1, 0, 4'hF, 4'h0, 0, 4'd4, 0, 0, 4'h0);
        add(5,  1, 0, 4'hF, 4'h0, 0, 4'd4, 0, 0, 4'hF);
        add(1,  0, 0, 4'hF, 4'h0, 0, 4'd0, 0, 0, 4'h0);
        add(1,  1, 1, 4'h0, 4'h0, 0, 4'd1, 0, 0, 4'h0);
        add(1,  1, 1, 4'h0, 4'h0, 0, 4'd2, 0, 0, 4'h0);
        add(1,  1, 0, 4'h0, 4'h0, 0, 4'd3, 0, 0, 4'h0);
        add(1,  1, 0, 4'hF, 4'h0, 0, 4'd4, 0, 0, 4'h0);
        add(1,  1, 0, 4'hF, 4'h0, 1, 4'd4, 0, 0, 4'hF);
        add(18, 1, 0, 4'hF, 4'h0, 0, 4'd4, 0, 0, 4'hF);
        add(1,  1, 0, 4'h0, 4'h0, 0, 4'd5, 0, 0, 4'hF);
        add(1,  1, 0, 4'h0, 4'h0, 0, 4'd6, 0, 0, 4'hF);
        add(7,  1, 0, 4'h0, 4'h0, 0, 4'd6, 0, 0, 4'hF);
        add(1,  1, 0, 4'h0, 4'h0, 0, 4'd7, 1, 0, 4'hF);

        // reset state
        #1 reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        compare_all("reset");
        check("reset_state", {124'h0, state}, 128'h0);
        reset = 1'b0;

        foreach (tbl[k]) begin
            pll_lock = tbl[k].lock; alldone = tbl[k].done; rx_prbs_err = tbl[k].err;
            checker_status = tbl[k].chk; rerun = tbl[k].rr;
            repeat (tbl[k].n) step();
            check($sformatf("vec%0d", k), {121'h0, state, test_pass, test_fail, inject_seen},
                  {121'h0, tbl[k].st, tbl[k].pass, tbl[k].fail, tbl[k].seen});
        end
        rerun = 1'b0; alldone = 1'b0; rx_prbs_err = '0; checker_status = '0;

        // ACTIVE: one-cycle count latency, saturation, clear beats increment
        rx_prbs_err = 4'b0010;
        step();
        check("cnt_latency", {112'h0, lane_err_cnt[EW +: EW]}, 128'd1);
        repeat (69999) step();
        check("cnt_sat", {112'h0, lane_err_cnt[EW +: EW]}, {112'h0, 16'hFFFF});
        check("cnt_lane0", {112'h0, lane_err_cnt[0 +: EW]}, 128'h0);
        prbscntreset_ext = 1'b1;
        step();
        check("cnt_clear", {111'h0, prbscntreset, lane_err_cnt[EW +: EW]}, {111'h0, 1'b1, 16'h0});
        prbscntreset_ext = 1'b0; rx_prbs_err = '0; error_inject_ext = 1'b1;
        step();
        check("ext_inject", {126'h0, error_inject, prbscntreset}, {126'h0, 2'b10});
        error_inject_ext = 1'b0;
        step();

        // asynchronous reset in the middle of CLEAR: no partial pass
        rerun = 1'b1; step(); rerun = 1'b0;
        step();
        rx_prbs_err = 4'hF; repeat (20) step();
        rx_prbs_err = '0;   repeat (5) step();
        check("pre_abort", {124'h0, state}, {124'h0, 4'd6});
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all("abort");
        @(posedge clk);
        #1;
        compare_all("abort_hold");
        reset = 1'b0;

        // randomized run against the model
        dead_mask = '0;
        for (int c = 0; c < 6000; c++) begin
            pll_lock = ($urandom_range(0, 299) != 0);
            alldone  = $urandom_range(0, 1) == 1;
            rerun    = ($urandom_range(0, 39) == 0);
            prbscntreset_ext = ($urandom_range(0, 7) == 0);
            error_inject_ext = $urandom_range(0, 1) == 1;
            if (m_state == S_RX)
                dead_mask = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
            if (m_state == S_INJ)
                rx_prbs_err = 4'($urandom) & ~dead_mask;
            else
                rx_prbs_err = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            checker_status = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'h0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
